// File: rtl/pwm.sv
// pwm: single-channel PWM generator with start/stop gating and period-boundary reload
module pwm (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] PERIOD,
  input  logic [15:0] ACTIVE,
  output logic        pulse
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, per_l, per_n, act_l, act_n;
  logic        pulse_n, wrap;
  assign wrap = (per_l == 16'd0) || (cnt == per_l - 16'd1);
  // next state, counter and shadow registers; pulse is precomputed from the next values so it leaves a flop
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per_l;
    act_n   = act_l;
    if (state == IDLE) begin
      cnt_n = '0;
      if (start && !stop) begin
        state_n = RUN;
        per_n   = PERIOD;
        act_n   = ACTIVE;
      end
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (wrap) begin
      cnt_n = '0;
      per_n = PERIOD;
      act_n = ACTIVE;
    end else begin
      cnt_n = cnt + 16'd1;
    end
    pulse_n = (state_n == RUN) && (per_n != 16'd0) && (cnt_n < act_n);
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      per_l <= '0;
      act_l <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      per_l <= per_n;
      act_l <= act_n;
      pulse <= pulse_n;
    end
  end
endmodule

// File: tb/tb_pwm.sv
// tb_pwm: directed checks of the pwm waveform, stop/start, reprogramming and boundary cases
module tb_pwm;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] PERIOD = '0;
  logic [15:0] ACTIVE = '0;
  logic        pulse;
  int          vectors = 0;
  int          miscompares = 0;

  pwm dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .PERIOD(PERIOD), .ACTIVE(ACTIVE), .pulse(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_pulse(int k, int p, int a);
    return (p == 0) ? 1'b0 : ((k % p) < a);
  endfunction

  task automatic run(input string tag, input int n, input int p, input int a);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(tag, {31'd0, pulse}, {31'd0, exp_pulse(k, p, a)});
    end
  endtask

  task automatic restart(input string tag, input int p, input int a);
    @(negedge clk);
    stop   = 1'b1;
    start  = 1'b1;
    PERIOD = p[15:0];
    ACTIVE = a[15:0];
    @(negedge clk);
    chk({tag, "_stopped"}, {31'd0, pulse}, 32'd0);
    stop = 1'b0;
  endtask

  initial begin
    int highs;
    start  = 1'b1;
    PERIOD = 16'd10;
    ACTIVE = 16'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_hold", {31'd0, pulse}, 32'd0);
    end
    reset = 1'b1;
    run("basic", 400, 10, 4);
    stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stop_hold", {31'd0, pulse}, 32'd0);
    end
    stop = 1'b0;
    run("stop_restart", 20, 10, 4);
    restart("reprog", 10, 4);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      chk("reprog", {31'd0, pulse}, {31'd0, (k < 10) ? exp_pulse(k, 10, 4) : exp_pulse(k - 10, 8, 2)});
      if (k == 2) begin
        PERIOD = 16'd8;
        ACTIVE = 16'd2;
      end
    end
    restart("act0", 10, 0);
    run("act0", 25, 10, 0);
    restart("full", 10, 10);
    run("full", 25, 10, 10);
    restart("over", 5, 9);
    run("over", 15, 5, 9);
    restart("per0", 0, 4);
    run("per0", 15, 0, 4);
    restart("per1", 1, 1);
    run("per1", 10, 1, 1);
    restart("rst_mid", 10, 4);
    @(negedge clk);
    chk("rst_mid_high", {31'd0, pulse}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("rst_async", {31'd0, pulse}, 32'd0);
    @(negedge clk);
    chk("rst_held", {31'd0, pulse}, 32'd0);
    reset = 1'b1;
    run("rst_release", 20, 10, 4);
    @(negedge clk);
    stop  = 1'b1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("simul", {31'd0, pulse}, 32'd0);
    end
    stop = 1'b0;
    run("simul_go", 20, 10, 4);
    restart("max", 16'hFFFF, 16'h8000);
    highs = 0;
    for (int k = 0; k < 65535; k++) begin
      @(negedge clk);
      highs += int'(pulse);
      if (k == 32767 || k == 32768 || k == 65534)
        chk("max_edge", {31'd0, pulse}, {31'd0, exp_pulse(k, 65535, 32768)});
    end
    chk("max_highs", highs, 32'd32768);
    @(negedge clk);
    chk("max_wrap", {31'd0, pulse}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
